// File: rtl/edcg_pkg.sv
// Shared constants and code definition for the SEC-DED Hamming(38,32) check-bit generator.
// Also used by the downstream corrector.
package edcg_pkg;

   localparam int DATA_W = 32;
   localparam int ECC_W  = 8;
   localparam int HAM_W  = 6;

   // Codeword position of each data bit: the non-power-of-two positions from 3 upward.
   localparam int unsigned POS [0:DATA_W-1] = '{
      3, 5, 6, 7,
      9, 10, 11, 12, 13, 14, 15,
      17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31,
      33, 34, 35, 36, 37, 38
   };

   // Data bits that contribute to Hamming check bit k.
   function automatic logic [DATA_W-1:0] pos_mask(input int unsigned k);
      logic [DATA_W-1:0] m;
      int unsigned       p;
      m = '0;
      for (int i = 0; i < DATA_W; i++) begin
         p    = POS[i];
         m[i] = ((p >> k) & 32'd1) != 32'd0;
      end
      return m;
   endfunction

   // G[5:0] Hamming bits, G[6] overall parity, G[7] data parity.
   function automatic logic [ECC_W-1:0] calc_g(input logic [DATA_W-1:0] d);
      logic [ECC_W-1:0] g;
      g = '0;
      for (int unsigned k = 0; k < HAM_W; k++) begin
         g[k] = ^(d & pos_mask(k));
      end
      g[7] = ^d;
      g[6] = g[7] ^ (^g[5:0]);
      return g;
   endfunction

endpackage

// File: rtl/edcg_parity.sv
// Combinational check-bit generator: 32-bit data word to the 8 stored/compared ECC bits.
module edcg_parity
   import edcg_pkg::*;
(
   input  logic [DATA_W-1:0] id,
   output logic [ECC_W-1:0]  g
);

   logic [HAM_W-1:0] hamming;
   logic             data_par;

   generate
      for (genvar gi = 0; gi < HAM_W; gi++) begin : g_ham
         localparam logic [DATA_W-1:0] MASK = pos_mask(gi);
         assign hamming[gi] = ^(id & MASK);
      end
   endgenerate

   assign data_par = ^id;

   // Overall parity covers the data bits and all six Hamming bits.
   assign g = {data_par, data_par ^ (^hamming), hamming};

endmodule

// File: rtl/edcg.sv
// ECC check-bit generator / syndrome checker: registers G (write) or G ^ IC (read)
// one cycle after each request.
module edcg
   import edcg_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req,
   input  logic              R,
   input  logic [ECC_W-1:0]  IC,
   input  logic [DATA_W-1:0] ID,
   output logic [ECC_W-1:0]  S,
   output logic              o_done
);

   logic [ECC_W-1:0] g;
   logic [ECC_W-1:0] s_next;

   edcg_parity u_parity (
      .id (ID),
      .g  (g)
   );

   assign s_next = R ? (g ^ IC) : g;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         S      <= '0;
         o_done <= 1'b0;
      end else begin
         if (i_req) begin
            S <= s_next;
         end
         o_done <= i_req;
      end
   end

endmodule

// File: tb/tb_edcg.sv
// Scoreboard bench for edcg: stimulus pushes expected S values, a negedge monitor pops and compares.
module tb_edcg;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        r;
   logic [7:0]  ic;
   logic [31:0] id;
   logic [7:0]  s;
   logic        done;

   int          n_cmp;
   int          n_err;
   logic [7:0]  exp_q[$];
   logic [7:0]  hold_exp;

   edcg dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_req   (req),
      .R       (r),
      .IC      (ic),
      .ID      (id),
      .S       (s),
      .o_done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: syndrome of set data bits is the XOR of their codeword positions.
   function automatic logic [7:0] ref_g(input logic [31:0] d);
      int         idx;
      logic [5:0] synd;
      logic       dpar;
      logic [7:0] g;
      idx  = 0;
      synd = '0;
      for (int p = 1; p <= 38; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (d[idx]) synd = synd ^ 6'(p);
            idx++;
         end
      end
      dpar = 1'($countones(d) % 2);
      g    = {dpar, dpar ^ 1'($countones(synd) % 2), synd};
      return g;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic issue(input logic [31:0] d, input logic rr, input logic [7:0] c, input logic [7:0] expv);
      @(posedge clk);
      #1;
      req = 1'b1;
      id  = d;
      r   = rr;
      ic  = c;
      exp_q.push_back(expv);
      $display("req id=0x%08h R=%0d IC=0x%02h exp S=0x%02h", d, rr, c, expv);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         req = 1'b0;
         id  = $urandom;
         ic  = 8'($urandom);
         r   = 1'($urandom);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_exp = 8'h00;
      end else if (done) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
         end else begin
            hold_exp = exp_q.pop_front();
            check("S_result", 32'(s), 32'(hold_exp));
         end
      end else begin
         check("S_hold", 32'(s), 32'(hold_exp));
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] d;
      logic [7:0]  c;
      logic        rr;
      logic [7:0]  g;
      n_cmp    = 0;
      n_err    = 0;
      hold_exp = 8'h00;
      rst_n    = 1'b0;
      req      = 1'b0;
      r        = 1'b0;
      ic       = 8'h00;
      id       = 32'h0;
      #2;
      check("reset_S", 32'(s), 32'h00);
      check("reset_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed vectors
      issue(32'h0000_0000, 1'b0, 8'hA5, 8'h00);
      issue(32'h0000_0001, 1'b0, 8'h00, 8'hC3);
      issue(32'h0000_0002, 1'b0, 8'hFF, 8'hC5);
      issue(32'h0000_0001, 1'b1, 8'hC3, 8'h00);
      issue(32'h0000_0000, 1'b1, 8'hC3, 8'hC3);
      idle(2);
      // Back-to-back then hold
      issue(32'h0000_0001, 1'b0, 8'h00, 8'hC3);
      issue(32'h0000_0002, 1'b0, 8'h00, 8'hC5);
      idle(3);

      // Mid-run asynchronous reset while a result is presented
      issue(32'h0000_0002, 1'b0, 8'h00, 8'hC5);
      @(posedge clk);
      #1;
      req = 1'b0;
      #1;
      check("pre_reset_S", 32'(s), 32'hC5);
      check("pre_reset_done", 32'(done), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_S", 32'(s), 32'h00);
      check("async_reset_done", 32'(done), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(32'h0000_0001, 1'b0, 8'h00, 8'hC3);
      idle(1);

      // Randomized traffic with optional single-bit data errors on the read path
      for (int t = 0; t < 300; t++) begin
         d  = $urandom;
         rr = 1'($urandom);
         if (rr && ($urandom_range(0, 2) == 0))
            c = ref_g(d ^ (32'd1 << $urandom_range(0, 31)));
         else
            c = 8'($urandom);
         g = ref_g(d);
         issue(d, rr, c, rr ? (g ^ c) : g);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(3);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
